// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: sync byte, length width
// and the frame-parser state encoding.
package imem_loader_pkg;

    localparam logic [7:0] LOADER_SYNC      = 8'hA5;
    localparam int         LOADER_LEN_WIDTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } loader_state_t;

    // A frame passes when the data bytes and the trailing checksum sum to zero mod 256.
    function automatic logic csum_ok(input logic [7:0] sum, input logic [7:0] csum);
        logic [7:0] total;
        total = sum + csum;
        return total == 8'h00;
    endfunction

endpackage

// File: rtl/imem_loader.sv
// Fills the byte-addressed instruction memory from a framed byte stream
// (A5, LEN_HI, LEN_LO, data..., CSUM) and releases the CPU once the checksum passes.
//
// state  | meaning
// IDLE   | hunting for the sync byte, other bytes discarded
// LEN_HI | next byte is length[15:8]
// LEN_LO | next byte is length[7:0], oversize length is rejected here
// DATA   | writing payload bytes to addresses 0..LEN-1
// CSUM   | next byte is the checksum
// DONE   | image verified, CPU released, a new sync byte restarts loading
// ERROR  | frame rejected, input stalled until reset
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES  = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam logic [LOADER_LEN_WIDTH-1:0] MAX_LEN = LOADER_LEN_WIDTH'(MEM_BYTES);

    loader_state_t               r_state;
    logic [LOADER_LEN_WIDTH-1:0] r_len;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic [7:0]                  r_sum;
    logic                        r_in_ready;
    logic                        r_mem_we;
    logic [ADDR_WIDTH-1:0]       r_mem_addr;
    logic [7:0]                  r_mem_wdata;
    logic                        r_cpu_reset;
    logic                        r_done;
    logic                        r_error;

    loader_state_t               w_state_nxt;
    logic [LOADER_LEN_WIDTH-1:0] w_len_nxt;
    logic [ADDR_WIDTH-1:0]       w_addr_nxt;
    logic [7:0]                  w_sum_nxt;
    logic                        w_we_nxt;
    logic [ADDR_WIDTH-1:0]       w_waddr_nxt;
    logic [7:0]                  w_wdata_nxt;
    logic                        w_accept;
    logic                        w_last_data;
    logic [LOADER_LEN_WIDTH-1:0] w_len_full;

    assign w_accept    = in_valid && r_in_ready;
    assign w_len_full  = {r_len[LOADER_LEN_WIDTH-1:8], in_data};
    // The address counter doubles as the payload byte index within the frame.
    assign w_last_data = (LOADER_LEN_WIDTH'(r_addr) + LOADER_LEN_WIDTH'(1)) == r_len;

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_addr_nxt  = r_addr;
        w_sum_nxt   = r_sum;
        w_we_nxt    = 1'b0;
        w_waddr_nxt = r_mem_addr;
        w_wdata_nxt = r_mem_wdata;

        if (w_accept) begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (in_data == LOADER_SYNC) begin
                        w_state_nxt = ST_LEN_HI;
                        w_addr_nxt  = '0;
                        w_sum_nxt   = 8'h00;
                    end
                end
                ST_LEN_HI: begin
                    w_len_nxt   = {in_data, r_len[7:0]};
                    w_state_nxt = ST_LEN_LO;
                end
                ST_LEN_LO: begin
                    w_len_nxt = w_len_full;
                    if (w_len_full > MAX_LEN) begin
                        w_state_nxt = ST_ERROR;
                    end else if (w_len_full == '0) begin
                        w_state_nxt = ST_CSUM;
                    end else begin
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = r_addr;
                    w_wdata_nxt = in_data;
                    w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
                    w_sum_nxt   = r_sum + in_data;
                    if (w_last_data) begin
                        w_state_nxt = ST_CSUM;
                    end
                end
                ST_CSUM: begin
                    w_state_nxt = csum_ok(r_sum, in_data) ? ST_DONE : ST_ERROR;
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_addr      <= '0;
            r_sum       <= 8'h00;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 8'h00;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_addr      <= w_addr_nxt;
            r_sum       <= w_sum_nxt;
            r_in_ready  <= (w_state_nxt != ST_ERROR);
            r_mem_we    <= w_we_nxt;
            r_mem_addr  <= w_waddr_nxt;
            r_mem_wdata <= w_wdata_nxt;
            r_cpu_reset <= (w_state_nxt != ST_DONE);
            r_done      <= (w_state_nxt == ST_DONE);
            r_error     <= (w_state_nxt == ST_ERROR);
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_reset = r_cpu_reset;
    assign done      = r_done;
    assign error     = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued as frames
// are sent, and a monitor pops and compares each observed write.
module tb_imem_loader;

    localparam int MEM_BYTES  = 1024;
    localparam int ADDR_WIDTH = 10;

    logic                  clk;
    logic                  reset;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [7:0]            mem_wdata;
    logic                  cpu_reset;
    logic                  done;
    logic                  error;

    imem_loader #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_reset(cpu_reset),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_WIDTH-1:0] addr;
        logic [7:0]            data;
    } wr_t;

    wr_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_wr(input int addr, input logic [7:0] data);
        wr_t w;
        w.addr = ADDR_WIDTH'(addr);
        w.data = data;
        sb.push_back(w);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tick();
        reset = 1'b0;
        tick();
    endtask

    // Presents one byte, waits (bounded) for acceptance, then idles for gap cycles.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: byte 0x%0h never accepted", b);
            in_valid = 1'b0;
            return;
        end
        tick();
        in_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_bytes(input logic [7:0] bytes[$], input int gap);
        foreach (bytes[i]) send_byte(bytes[i], gap);
    endtask

    task automatic push_deadbeef();
        push_wr(0, 8'hDE);
        push_wr(1, 8'hAD);
        push_wr(2, 8'hBE);
        push_wr(3, 8'hEF);
    endtask

    task automatic check_status(input string tag, input logic exp_done,
                                input logic exp_cpu_reset, input logic exp_error);
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_cpu_reset"}, 32'(cpu_reset), 32'(exp_cpu_reset));
        check({tag, "_error"}, 32'(error), 32'(exp_error));
    endtask

    logic [7:0] frame_ok[$]  = '{8'hA5, 8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hC8};
    logic [7:0] frame_bad[$] = '{8'h00, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00};

    initial begin
        fork
            forever begin
                @(negedge clk);
                if (mem_we) begin
                    if (sb.size() == 0) begin
                        check("unexpected_write_addr", 32'(mem_addr), 32'hFFFF_FFFF);
                    end else begin
                        wr_t e;
                        e = sb.pop_front();
                        check("write_addr", 32'(mem_addr), 32'(e.addr));
                        check("write_data", 32'(mem_wdata), 32'(e.data));
                    end
                end
            end
            begin
                #2ms;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog");
            end
        join_none

        // Reset values, sampled while reset is held
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hA5;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check_status("rst", 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        reset    = 1'b0;
        tick();
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Basic frame
        push_deadbeef();
        send_bytes(frame_ok, 0);
        check_status("s1", 1'b1, 1'b0, 1'b0);
        check("s1_drain", 32'(sb.size()), 32'd0);

        // Restart from DONE, then a bad checksum
        send_byte(8'hA5, 0);
        check_status("s2_restart", 1'b0, 1'b1, 1'b0);
        push_deadbeef();
        send_bytes(frame_bad, 0);
        check_status("s2", 1'b0, 1'b1, 1'b1);
        check("s2_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'hA5;
        repeat (4) tick();
        in_valid = 1'b0;
        check_status("s2_hold", 1'b0, 1'b1, 1'b1);
        check("s2_hold_in_ready", 32'(in_ready), 32'd0);
        check("s2_drain", 32'(sb.size()), 32'd0);

        // Leading garbage bytes
        do_reset();
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        push_deadbeef();
        send_bytes(frame_ok, 0);
        check_status("s3", 1'b1, 1'b0, 1'b0);
        check("s3_drain", 32'(sb.size()), 32'd0);

        // Oversize length 0x0401
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'h01, 0);
        check_status("s4", 1'b0, 1'b1, 1'b1);
        check("s4_in_ready", 32'(in_ready), 32'd0);

        // Zero length
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        check_status("s5_pre", 1'b0, 1'b1, 1'b0);
        send_byte(8'h00, 0);
        check_status("s5", 1'b1, 1'b0, 1'b0);

        // Gapped frame
        do_reset();
        push_deadbeef();
        send_bytes(frame_ok, 1);
        check_status("s6", 1'b1, 1'b0, 1'b0);
        check("s6_drain", 32'(sb.size()), 32'd0);

        // Reset mid-frame then resend
        do_reset();
        push_wr(0, 8'hDE);
        push_wr(1, 8'hAD);
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h04, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        check("s7_mid_cpu_reset", 32'(cpu_reset), 32'd1);
        reset = 1'b1;
        tick();
        check("s7_rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("s7_rst_mem_addr", 32'(mem_addr), 32'd0);
        reset = 1'b0;
        tick();
        check("s7_drain_partial", 32'(sb.size()), 32'd0);
        push_deadbeef();
        send_bytes(frame_ok, 0);
        check_status("s7", 1'b1, 1'b0, 1'b0);
        check("s7_drain", 32'(sb.size()), 32'd0);

        // Maximum length: 1024 bytes of i[7:0]; their sum is 0 mod 256, so CSUM is 00
        do_reset();
        send_byte(8'hA5, 0);
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < MEM_BYTES; i++) begin
            push_wr(i, 8'(i));
            send_byte(8'(i), 0);
        end
        check_status("max_pre", 1'b0, 1'b1, 1'b0);
        send_byte(8'h00, 0);
        check_status("max", 1'b1, 1'b0, 1'b0);
        check("max_drain", 32'(sb.size()), 32'd0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Hardware front end that fills the processor's byte-addressed instruction memory from a framed byte stream, then releases the CPU. It does in RTL what the test benches do with a backdoor memory preload, so a program image can arrive over a link instead. It sits between an external byte source (valid/ready) and the instruction memory write port. It holds the processor in reset until a frame has been written and its checksum has passed.

## Interface
Parameters:
- `MEM_BYTES`, 1024, instruction memory size in bytes.
- `ADDR_WIDTH`, 10, byte address width. Must satisfy 2^ADDR_WIDTH >= MEM_BYTES.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  source has a byte on `in_data`.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `mem_we`  out  1  byte write strobe to instruction memory.
- `mem_addr`  out  ADDR_WIDTH  byte address.
- `mem_wdata`  out  8  byte to write.
- `cpu_reset`  out  1  holds the processor in reset while high.
- `done`  out  1  last frame loaded and verified.
- `error`  out  1  frame rejected; sticky until `reset`.

## Operation
- A byte is accepted on an edge where `in_valid && in_ready`.
- Frame format: sync byte 0xA5, LEN_HI, LEN_LO, then LEN data bytes, then CSUM.
- CSUM is valid when (sum of data bytes + CSUM) mod 256 == 0.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR.
- IDLE: a byte equal to 0xA5 moves to LEN_HI. Any other byte is accepted and discarded.
- LEN_HI: store the byte as length[15:8], then go to LEN_LO.
- LEN_LO: store the byte as length[7:0], then:
  - if length > MEM_BYTES, go to ERROR;
  - if length == 0, go to CSUM;
  - otherwise go to DATA.
- DATA: the k-th accepted byte (k from 0) is written to address k, and the 8-bit running sum is updated. After byte LEN-1, go to CSUM.
- CSUM: if the check passes, go to DONE; otherwise go to ERROR.
- DONE: `done`=1 and `cpu_reset`=0. `in_ready` stays 1. Non-0xA5 bytes are discarded. A 0xA5 byte starts a new frame:
  - `done` drops and `cpu_reset` rises on that edge;
  - the address counter and sum clear;
  - the FSM goes to LEN_HI.
- ERROR: `error`=1, `cpu_reset`=1, `in_ready`=0. Only `reset` leaves this state.
- Address counter and checksum are cleared whenever a frame starts.
- Address arithmetic is ADDR_WIDTH bits. The length check guarantees the counter never wraps within a frame.
- Byte order in memory equals stream order, i.e. the same image layout as the `$readmemb` byte files.

## Timing
- Reset values: state IDLE, `in_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_reset`=1, `done`=0, `error`=0. The counter and sum are 0.
- `in_ready` is registered. It is 1 from the first cycle after `reset` deasserts, in every state except ERROR.
- Write latency is 1 cycle. A DATA byte accepted at edge n produces `mem_we`=1 with its address and data during the cycle after edge n. `mem_we` is 0 in every other cycle, including cycles where `in_valid` is low.
- `done`, `error` and `cpu_reset` update on the edge that accepts CSUM. For an oversize length, `error` updates on the edge that accepts LEN_LO.
- A full frame takes LEN+4 accepted bytes. With back-to-back `in_valid`, that is LEN+4 cycles.
- Reset asserted mid-frame returns to reset values on that edge. Bytes already written are not undone; the next frame overwrites from address 0.
- If `reset` and a valid byte coincide, `reset` wins and the byte is dropped.

## Structure
- Shared package holds:
  - `LOADER_SYNC` = 8'hA5;
  - the FSM state encoding (7 states, 3 bits);
  - `LOADER_LEN_WIDTH` = 16.
- Single module with no sub-module. The checksum accumulator and address counter are plain registers inside the FSM block.

## Test plan
- Frame A5 00 04 DE AD BE EF C8 -> writes DE,AD,BE,EF to addresses 0..3 in four consecutive `mem_we` cycles. After the C8 edge, `done`=1, `cpu_reset`=0, `error`=0.
- Same frame with CSUM 00 -> four writes occur, then `error`=1, `cpu_reset`=1, `in_ready`=0. These hold until `reset`; a later A5 is not accepted.
- Leading bytes 11 22 before a valid frame -> no `mem_we` for them, and the load completes as in the first scenario.
- A5 04 01 with MEM_BYTES=1024 -> `error`=1 on the LEN_LO edge, and `mem_we` never asserts.
- A5 00 00 00 -> no writes, `done`=1.
- First-scenario frame with one idle `in_valid`=0 cycle between each byte -> identical writes and result, with no `mem_we` in idle cycles.
- `reset` pulsed after the second DATA byte, then the first-scenario frame resent -> `cpu_reset`=1 throughout. Writes restart at address 0, and the load ends with `done`=1.
